// File: rtl/sevenseg_pkg.sv
// Shared seven-segment types, constants and the hex decode table.
package sevenseg_pkg;

  // Segment vector in {G,F,E,D,C,B,A} order, active-low.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex nibble to active-low segment pattern (lower-case b and d).
  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational nibble-to-segment decoder, shareable by other display blocks.
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// value update, PWM brightness and optional leading-zero suppression.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DUTY_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lz_blank_i,
  input  logic [DUTY_W-1:0]       brightness_i,
  output seg_t                    seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_value_q, disp_value_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, disp_blank_q;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DUTY_W-1:0] pwm_q;
  logic              slot_wrap, frame_bnd;

  logic [NUM_DIGITS-1:0] lz_sup;
  logic                  lz_run;
  logic [3:0]            cur_nibble;
  logic                  cur_dp, cur_blank, cur_sup;
  seg_t                  cur_seg;
  logic                  pwm_en, lit;

  seg_t                  seg_d;
  logic                  dp_d, frame_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Shadow captures loads; display copies shadow only at frame boundaries.
  // Reset clears both, so the first cycle after release needs no extra copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      disp_value_q   <= '0;
      disp_dp_q      <= '0;
      disp_blank_q   <= '0;
    end else begin
      if (load_i) begin
        shadow_value_q <= value_i;
        shadow_dp_q    <= dp_i;
        shadow_blank_q <= blank_i;
      end
      if (frame_bnd) begin
        disp_value_q <= shadow_value_q;
        disp_dp_q    <= shadow_dp_q;
        disp_blank_q <= shadow_blank_q;
      end
    end
  end

  // Slot counter, digit index and free-running PWM counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      idx_q  <= '0;
      pwm_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      pwm_q  <= pwm_q + 1'b1;
    end
  end

  // Next slot/digit and frame boundary detection.
  always_comb begin
    slot_wrap = (slot_q == SLOT_LAST);
    frame_bnd = slot_wrap && (idx_q == IDX_LAST);
    slot_d    = slot_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Leading-zero mask: walk down from the top digit while nibble and dp are clear.
  always_comb begin
    lz_sup = '0;
    lz_run = lz_blank_i;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      lz_run    = lz_run && (disp_value_q[4*k +: 4] == 4'h0) && !disp_dp_q[k];
      lz_sup[k] = lz_run;
    end
  end

  // Select the current digit's display fields.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_sup    = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (IDX_W'(k) == idx_q) begin
        cur_nibble = disp_value_q[4*k +: 4];
        cur_dp     = disp_dp_q[k];
        cur_blank  = disp_blank_q[k];
        cur_sup    = lz_sup[k];
      end
    end
  end

  sevenseg_decoder u_decoder (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Output next-state: dark by default, lit digit drives its anode and segments.
  always_comb begin
    pwm_en  = (brightness_i == {DUTY_W{1'b1}}) || (pwm_q < brightness_i);
    lit     = pwm_en && !cur_blank && !cur_sup;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    an_d    = '1;
    frame_d = (slot_q == '0) && (idx_q == '0);
    if (lit) begin
      seg_d = cur_seg;
      dp_d  = ~cur_dp;
      // Last cycle of a slot keeps anodes off to avoid ghosting into the next digit.
      an_d  = slot_wrap ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o   <= SEG_BLANK;
      dp_o    <= 1'b1;
      an_o    <= '1;
      frame_o <= 1'b0;
    end else begin
      seg_o   <= seg_d;
      dp_o    <= dp_d;
      an_o    <= an_d;
      frame_o <= frame_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench: scoreboard of per-digit expectations for a fast-scan
// instance, plus a slower instance for PWM duty measurement.
module tb_sevenseg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, load, lz;
  logic [31:0] value;
  logic [7:0]  dp_in, blank_in;
  logic [3:0]  bright_a, bright_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, frame_a, frame_b;
  logic [7:0]  an_a, an_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int          cnt_q[$];

  sevenseg_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(4), .DUTY_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value), .dp_i(dp_in),
    .blank_i(blank_in), .lz_blank_i(lz), .brightness_i(bright_a),
    .seg_o(seg_a), .dp_o(dp_a), .an_o(an_a), .frame_o(frame_a)
  );

  sevenseg_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(64), .DUTY_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value), .dp_i(dp_in),
    .blank_i(blank_in), .lz_blank_i(lz), .brightness_i(bright_b),
    .seg_o(seg_b), .dp_o(dp_b), .an_o(an_b), .frame_o(frame_b)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  task automatic push_digit(input logic [7:0] an, input logic [6:0] seg, input logic dp);
    exp_q.push_back({an, seg, dp});
  endtask

  task automatic push_dark();
    push_digit(8'hFF, 7'h7F, 1'b1);
  endtask

  // Expected frame for a loaded value without leading-zero suppression.
  task automatic push_value(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b);
    logic [7:0] an;
    for (int k = 0; k < 8; k++) begin
      an = ~(8'h01 << k);
      if (b[k]) push_dark();
      else      push_digit(an, seg_of(v[4*k +: 4]), ~d[k]);
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b);
    value = v; dp_in = d; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame_a();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_a && n < 100);
    checks++;
    if (frame_a !== 1'b1) begin
      errors++;
      $display("FAIL frame_a_timeout: frame_o=%b required 1", frame_a);
    end
  endtask

  task automatic wait_frame_b();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_b && n < 1200);
    checks++;
    if (frame_b !== 1'b1) begin
      errors++;
      $display("FAIL frame_b_timeout: frame_o=%b required 1", frame_b);
    end
  endtask

  // Called on the frame_o cycle: samples each digit slot and its guard cycle.
  task automatic check_frame_body(input string name);
    logic [15:0] exp, got;
    for (int off = 1; off < 32; off++) begin
      @(negedge clk);
      if (off % 4 == 1) begin
        got = {an_a, seg_a, dp_a};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_d%0d: scoreboard empty, got %h", name, off / 4, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL %s_d%0d: {an,seg,dp} got %h/%h/%b required %h/%h/%b", name,
                     off / 4, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
          end
        end
      end
      if (off % 4 == 3) begin
        checks++;
        if (an_a !== 8'hFF) begin
          errors++;
          $display("FAIL %s_guard%0d: an_o got %h required ff", name, off / 4, an_a);
        end
      end
    end
  endtask

  task automatic check_frame_a(input string name);
    wait_frame_a();
    check_frame_body(name);
  endtask

  task automatic measure_period(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_a && n < 100);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL %s: frame period got %0d required 32", name, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_in = '0; lz = 1'b0;
    bright_a = 4'hF; bright_b = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if ({an_a, seg_a, dp_a, frame_a} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: an/seg/dp/frame got %h/%h/%b/%b required ff/7f/1/0",
               an_a, seg_a, dp_a, frame_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({frame_a, an_a, seg_a, dp_a} !== {1'b1, 8'hFE, 7'h40, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_frame: frame/an/seg/dp got %b/%h/%h/%b required 1/fe/40/1",
               frame_a, an_a, seg_a, dp_a);
    end
    push_value(32'h0, 8'h0, 8'h0);
    check_frame_body("reset_frame");
    wait_frame_a();
    measure_period("reset_period");
  endtask

  task automatic test_load();
    wait_frame_a();
    do_load(32'h89ABCDEF, 8'h01, 8'h00);
    push_value(32'h89ABCDEF, 8'h01, 8'h00);
    check_frame_a("load");
  endtask

  task automatic test_lz();
    wait_frame_a();
    lz = 1'b1;
    do_load(32'h00000120, 8'h00, 8'h00);
    push_digit(8'hFE, 7'h40, 1'b1);
    push_digit(8'hFD, 7'h24, 1'b1);
    push_digit(8'hFB, 7'h79, 1'b1);
    repeat (5) push_dark();
    check_frame_a("lz_120");
    wait_frame_a();
    do_load(32'h0, 8'h00, 8'h00);
    push_digit(8'hFE, 7'h40, 1'b1);
    repeat (7) push_dark();
    check_frame_a("lz_zero");
    // A lit decimal point stops suppression at and below its digit.
    wait_frame_a();
    do_load(32'h0, 8'h10, 8'h00);
    push_digit(8'hFE, 7'h40, 1'b1);
    push_digit(8'hFD, 7'h40, 1'b1);
    push_digit(8'hFB, 7'h40, 1'b1);
    push_digit(8'hF7, 7'h40, 1'b1);
    push_digit(8'hEF, 7'h40, 1'b0);
    repeat (3) push_dark();
    check_frame_a("lz_dp");
    lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    wait_frame_a();
    do_load(32'h01234567, 8'h00, 8'h00);
    push_value(32'h01234567, 8'h00, 8'h00);
    check_frame_a("pre_coincide");
    // Load lands in the frame-boundary cycle (internal digit 7, last slot cycle).
    wait_frame_a();
    repeat (30) @(negedge clk);
    do_load(32'h76543210, 8'h00, 8'h00);
    push_value(32'h01234567, 8'h00, 8'h00);
    check_frame_a("coincide_old");
    push_value(32'h76543210, 8'h00, 8'h00);
    check_frame_a("coincide_new");
    wait_frame_a();
    do_load(32'hFEDCBA98, 8'hAA, 8'h00);
    repeat (5) @(negedge clk);
    do_load(32'h13579BDF, 8'h81, 8'h14);
    push_value(32'h13579BDF, 8'h81, 8'h14);
    check_frame_a("last_load_wins");
  endtask

  // Counts lit anode cycles per 16-cycle window across digit 0's 64-cycle slot.
  task automatic measure_duty(input string name);
    int lit;
    wait_frame_b();
    for (int w = 0; w < 4; w++) begin
      lit = 0;
      for (int c = 0; c < 16; c++) begin
        if (w != 0 || c != 0) @(negedge clk);
        if (an_b === 8'hFE) lit++;
        else if (an_b !== 8'hFF) begin
          checks++;
          errors++;
          $display("FAIL %s_anode: an_o got %h required fe or ff", name, an_b);
        end
      end
      checks++;
      if (cnt_q.size() == 0) begin
        errors++;
        $display("FAIL %s_w%0d: scoreboard empty, got %0d", name, w, lit);
      end else if (lit != cnt_q[0]) begin
        errors++;
        $display("FAIL %s_w%0d: lit cycles got %0d required %0d", name, w, lit, cnt_q[0]);
        void'(cnt_q.pop_front());
      end else begin
        void'(cnt_q.pop_front());
      end
    end
  endtask

  task automatic test_brightness();
    bright_b = 4'd4;
    repeat (4) cnt_q.push_back(4);
    measure_duty("duty4");
    bright_b = 4'd0;
    repeat (4) cnt_q.push_back(0);
    measure_duty("duty0");
    bright_b = 4'hF;
  endtask

  task automatic test_reset_mid();
    wait_frame_a();
    repeat (21) @(negedge clk);
    checks++;
    if (an_a !== 8'hDF) begin
      errors++;
      $display("FAIL mid_digit5: an_o got %h required df", an_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an_a, seg_a, dp_a, frame_a} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_async_reset: an/seg/dp/frame got %h/%h/%b/%b required ff/7f/1/0",
               an_a, seg_a, dp_a, frame_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({frame_a, an_a, seg_a} !== {1'b1, 8'hFE, 7'h40}) begin
      errors++;
      $display("FAIL mid_restart: frame/an/seg got %b/%h/%h required 1/fe/40",
               frame_a, an_a, seg_a);
    end
    measure_period("mid_period");
  endtask

  initial begin
    test_reset();
    test_load();
    test_lz();
    test_back_to_back();
    test_brightness();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit, common-anode seven-segment display.
- Holds a loadable hex value with per-digit decimal points and blanking.
- Scans one digit per refresh slot, decodes hex 0-F to active-low segments, and applies PWM brightness and optional leading-zero suppression.
- Sits between user logic and the board display pins, replacing static switch-selected anode drive.

Parameters:
- NUM_DIGITS, 8: number of digits/anodes; legal range 2..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= 2.
- DUTY_W, 4: brightness resolution in bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_i  in  1  single-cycle strobe; captures value_i/dp_i/blank_i into shadow registers
- value_i  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k; digit 0 is rightmost
- dp_i  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_i  in  NUM_DIGITS  force digit dark, 1 = blank
- lz_blank_i  in  1  enable leading-zero suppression
- brightness_i  in  DUTY_W  PWM duty; 0 = off, all-ones = 100%
- seg_o  out  7  segments {G,F,E,D,C,B,A}, active-low
- dp_o  out  1  decimal point, active-low
- an_o  out  NUM_DIGITS  anodes, active-low, one-hot-low when lit
- frame_o  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs are registered.
  - Reset values: seg_o=7'h7F, dp_o=1, an_o=all ones, frame_o=0.
  - Shadow, display, slot counter, digit index and PWM counter clear to 0.
- Slot counter: counts 0..REFRESH_DIV-1 and wraps.
- Digit index: increments on the wrap, and wraps from NUM_DIGITS-1 back to 0.
- Frame boundary: slot counter wrap with digit index NUM_DIGITS-1 (and the first cycle after reset release).
  - At a frame boundary the display registers copy the shadow registers, so there is no mid-frame tearing.
  - frame_o pulses in the same cycle the outputs first show digit 0.
- Load: load_i captures the shadow registers on the next clk edge.
  - Load and frame boundary in the same cycle: the display takes the old shadow; the new value appears next frame.
  - Repeated loads within one frame: the last load wins.
- PWM counter: DUTY_W bits, free-running, increments every cycle.
  - Digit enabled when brightness_i is all-ones, or when pwm < brightness_i.
- Digit k is lit when all hold:
  - enabled by PWM;
  - blank_i[k]=0;
  - not leading-zero suppressed.
- Leading-zero suppression (lz_blank_i=1):
  - Digit k is suppressed if its nibble and every higher nibble are 0 and all those digits have dp=0.
  - Digit 0 is never suppressed.
  - Evaluated on display registers, not shadow.
- Lit digit outputs: an_o has bit [index] low; seg_o = decode(nibble); dp_o = ~dp.
- Dark digit outputs: an_o all ones, seg_o=7'h7F, dp_o=1.
- Latency: outputs reflect the internal digit index/PWM state with exactly 1 cycle latency.
- Anode ghosting guard: in the final cycle of each slot, an_o is forced all ones.
- Decode table (active-low, {G..A}):
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Reset mid-frame: outputs go dark immediately; scanning restarts from digit 0 after release.

Decomposition:
- Package sevenseg_pkg holds:
  - SEG_BLANK constant (7'h7F);
  - segment-order typedef seg_t (logic [6:0]);
  - function hex_to_seg(nibble) returning seg_t.
- One natural sub-module, sevenseg_decoder: combinational nibble-to-segment wrapper around hex_to_seg.
  - Reusable by other display blocks; instantiated once for the current digit.

Test Plan:
- Reset with brightness=all-ones, REFRESH_DIV=4, NUM_DIGITS=8, no load -> first frame shows digit 0 "0": an_o=8'hFE, seg_o=7'h40; frame_o pulses every 32 cycles.
- load value=32'h89ABCDEF, dp_i=8'h01 -> from the next frame, the digit 0 slot shows seg_o=7'h0E, dp_o=0; the digit 7 slot shows seg_o=7'h00, an_o=8'h7F.
- lz_blank_i=1, value=32'h00000120 -> digits 7..3 have an_o all ones in their slots; digits 2..0 show 1, 2, 0; value=0 -> only digit 0 lit, showing "0".
- brightness_i=4 (DUTY_W=4), REFRESH_DIV=64 -> per 64-cycle slot, the anode is low 4 of every 16 cycles, excluding the final guard cycle; brightness_i=0 -> an_o never low.
- load_i coincident with the frame boundary cycle -> the current frame shows the previous value and the new value appears one frame later; two loads within one frame -> only the second is displayed.
- rst_n asserted mid-slot on digit 5 -> an_o=all ones, seg_o=7'h7F asynchronously; after release, scanning restarts at digit 0 with a frame_o pulse.
